disp_demux: RTL and testbench
=============================

# disp_demux

Scanned seven-segment display demultiplexer. It is the receiving end of the 4-digit time-multiplexed display bus: it watches the active-low digit enables and the segment byte, and recovers the four per-digit segment patterns as stable parallel registers. It sits beside the display driver, in hardware loopback self-test or as a capture front end for an external scanned display. It also flags illegal enable patterns and pulses once per completed scan frame.

## Interface
Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before a capture (legal range 2..255)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- an  input  4  digit enables, active-low, asynchronous to clk
- sseg  input  8  segment pattern for the enabled digit, asynchronous to clk
- out0, out1, out2, out3  output  8 each  captured segment pattern per digit (registered)
- digit_valid  output  4  bit k sticky-high once out_k has been captured since reset
- frame_tick  output  1  one-cycle pulse when all four digits have been captured since the last tick
- scan_err  output  1  one-cycle pulse on a stable, illegal enable pattern

## Operation
- Synchronizer: {an, sseg} (12 bits) pass through two flops (s1, s2), then a third flop s3 holds the previous sample.
- Stability counter cnt (8 bits):
  - if s2 != s3, cnt <= 0
  - else if cnt < STABLE_CYCLES, cnt <= cnt+1 (saturates)
- Capture strobe cap = (s2 == s3) && (cnt == STABLE_CYCLES-1). It fires exactly once per stable episode. Nothing is re-captured until the sample changes and settles again.
- On cap, decode an of s2:
  - 4'b1110 → digit 0; 4'b1101 → digit 1; 4'b1011 → digit 2; 4'b0111 → digit 3. out_k <= sseg, digit_valid[k] <= 1, seen[k] <= 1.
  - 4'b1111 (blanking) → ignored. No capture, no error.
  - Any other value (zero or two-plus bits low) → scan_err pulses. Outputs and seen are unchanged.
- Frame tracking: 4-bit seen mask, independent of scan order.
  - When a capture makes seen == 4'b1111, frame_tick pulses on the same edge as the out_k update, and seen clears to 4'b0000 (the completing digit is not carried over).
  - A capture of a digit already in seen just rewrites out_k. seen is unchanged.
- Reset (async assert, sync deassert by clk domain use):
  - s1/s2/s3 load an=4'b1111, sseg=8'hFF; cnt=0.
  - out0..out3=8'h00, digit_valid=0, seen=0, frame_tick=0, scan_err=0.

## Timing
- Latency: new input value first sampled at edge E0. If it is held through E0..E(STABLE_CYCLES), out_k, digit_valid, frame_tick and scan_err update at edge E(STABLE_CYCLES+2). With default 16, that is 18 edges.
- Minimum per-digit dwell for guaranteed capture: STABLE_CYCLES+1 clk edges. A change in the middle of a dwell restarts the count. Glitches shorter than the dwell are never captured.
- frame_tick and scan_err are exactly one cycle wide and never both high in the same cycle.
- Reset asserted mid-count or mid-frame discards all progress. After release, the first capture needs a full fresh dwell.
- The input equal to the reset value (1111/FF) right after reset is treated as blanking. No capture occurs.

## Test plan
- Reset: drive reset=0 with random inputs → all outputs 0. Release with an=1111 for 100 cycles → no pulses, digit_valid=0.
- Normal scan: cycle an 1110/1101/1011/0111 with sseg 8'hC0/8'hF9/8'hA4/8'hB0, 64 cycles per digit. Expect out0..out3 = C0/F9/A4/B0, digit_valid=1111, and frame_tick pulses after the 4th digit's capture at E0+18, then once per full scan.
- Short dwell: an=1101 with sseg=8'h99 held 16 edges, then 1111 → out1 unchanged, no pulse. Held 17 edges → out1=8'h99 at edge 18.
- Illegal enable: an=1100 held 40 cycles → scan_err pulses once, 1 cycle wide. Outputs, digit_valid and seen unchanged.
- Order independence and repeats: capture digits 2,2,0,3,1 → frame_tick only on the digit 1 capture. out2 holds the second digit-2 value.
- Reset mid-frame: capture digits 0 and 1, assert reset for 3 cycles, release, then capture 2 and 3 → no frame_tick. digit_valid=1100.

Source files
------------

// File: rtl/disp_demux_if.sv
// Scanned display bus as seen by the demultiplexer: the multiplexed
// enable/segment inputs plus the recovered per-digit registers and pulses.
interface disp_demux_if;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic [3:0] digit_valid;
    logic       frame_tick;
    logic       scan_err;

    // Driver side: produces the scanned bus, observes the recovered digits.
    modport master (
        output an, sseg,
        input  out0, out1, out2, out3, digit_valid, frame_tick, scan_err
    );

    // Demultiplexer side.
    modport slave (
        input  an, sseg,
        output out0, out1, out2, out3, digit_valid, frame_tick, scan_err
    );
endinterface

// File: rtl/disp_demux.sv
// disp_demux: recovers four stable digit patterns from a time-multiplexed
// seven-segment bus. Inputs are synchronized, debounced by a stability
// counter, then decoded into per-digit registers with frame and error pulses.
module disp_demux #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    disp_demux_if.slave   bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAP_AT  = 8'(STABLE_CYCLES - 1);

    // {an, sseg}: s1/s2 form the synchronizer, s3 is the previous sample.
    logic [11:0] s1, s2, s3;
    logic [7:0]  cnt;
    logic        cap;
    logic [3:0]  sel;
    logic        blank;
    logic [3:0]  seen;
    logic [3:0]  seen_next;

    logic [7:0]  out0_r, out1_r, out2_r, out3_r;
    logic [3:0]  digit_valid_r;
    logic        frame_tick_r;
    logic        scan_err_r;

    // One-hot digit select for a legal single-low enable, zero otherwise.
    function automatic logic [3:0] digit_sel(input logic [3:0] an);
        case (an)
            4'b1110: digit_sel = 4'b0001;
            4'b1101: digit_sel = 4'b0010;
            4'b1011: digit_sel = 4'b0100;
            4'b0111: digit_sel = 4'b1000;
            default: digit_sel = 4'b0000;
        endcase
    endfunction

    // Synchronize the bus and count how long the sample has been unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 12'hFFF;
            s2  <= 12'hFFF;
            s3  <= 12'hFFF;
            cnt <= 8'd0;
        end else begin
            s1 <= {bus.an, bus.sseg};
            s2 <= s1;
            s3 <= s2;
            if (s2 != s3)
                cnt <= 8'd0;
            else if (cnt < CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    // Capture strobe and decode; the saturating count makes cap fire once per episode.
    always_comb begin
        cap       = (s2 == s3) && (cnt == CAP_AT);
        sel       = digit_sel(s2[11:8]);
        blank     = (s2[11:8] == 4'hF);
        seen_next = seen | sel;
    end

    // Update digit registers, frame tracking and the one-cycle pulses on capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0_r        <= 8'h00;
            out1_r        <= 8'h00;
            out2_r        <= 8'h00;
            out3_r        <= 8'h00;
            digit_valid_r <= 4'b0000;
            seen          <= 4'b0000;
            frame_tick_r  <= 1'b0;
            scan_err_r    <= 1'b0;
        end else begin
            frame_tick_r <= 1'b0;
            scan_err_r   <= 1'b0;
            if (cap) begin
                if (sel != 4'b0000) begin
                    if (sel[0]) out0_r <= s2[7:0];
                    if (sel[1]) out1_r <= s2[7:0];
                    if (sel[2]) out2_r <= s2[7:0];
                    if (sel[3]) out3_r <= s2[7:0];
                    digit_valid_r <= digit_valid_r | sel;
                    // The completing digit starts no credit toward the next frame.
                    if (seen_next == 4'hF) begin
                        frame_tick_r <= 1'b1;
                        seen         <= 4'b0000;
                    end else begin
                        seen <= seen_next;
                    end
                end else if (!blank) begin
                    scan_err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.out0        = out0_r;
    assign bus.out1        = out1_r;
    assign bus.out2        = out2_r;
    assign bus.out3        = out3_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.frame_tick  = frame_tick_r;
    assign bus.scan_err    = scan_err_r;

endmodule

// File: tb/tb_disp_demux.sv
// Bench for disp_demux: table of dwell vectors, hand sequences for frame and
// reset corners, and random scans, all checked every cycle against a model.
module tb_disp_demux;

    localparam int S = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    disp_demux_if bus ();

    disp_demux #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: a sample value held for S+1 consecutive edges
    // takes effect two edges after its last required sample.
    typedef struct { int due; logic [11:0] v; } ev_t;
    ev_t         evq[$];
    logic [7:0]  m_out [4];
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    logic        m_tick;
    logic        m_err;
    logic [11:0] m_prev;
    int          m_run;
    int          ecount = 0;
    int          p_tick;
    int          p_err;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  sseg;
        int          hold;
        logic [31:0] outs;
        logic [3:0]  valid;
        int          ticks;
        int          errs;
    } vec_t;
    vec_t tbl [9];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
        m_valid = 4'b0000;
        m_seen  = 4'b0000;
        m_tick  = 1'b0;
        m_err   = 1'b0;
        m_prev  = 12'hFFF;
        m_run   = 0;
        evq.delete();
    endfunction

    function automatic void apply_cap(logic [11:0] v);
        logic [3:0] a;
        a = v[11:8];
        if (a == 4'hF) return;
        if ($countones(a) == 3) begin
            for (int k = 0; k < 4; k++)
                if (!a[k]) begin
                    m_out[k]   = v[7:0];
                    m_valid[k] = 1'b1;
                    m_seen[k]  = 1'b1;
                end
            if (m_seen == 4'hF) begin
                m_tick = 1'b1;
                m_seen = 4'b0000;
            end
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_edge(logic [11:0] smp);
        m_tick = 1'b0;
        m_err  = 1'b0;
        if (evq.size() > 0 && evq[0].due == ecount) begin
            apply_cap(evq[0].v);
            void'(evq.pop_front());
        end
        if (smp == m_prev) m_run++;
        else begin
            m_run  = 1;
            m_prev = smp;
        end
        if (m_run == S + 1) evq.push_back('{ecount + 2, smp});
    endfunction

    // One clock edge: advance the model, then compare every output.
    task automatic tick();
        @(posedge clk);
        ecount++;
        model_edge({bus.an, bus.sseg});
        #1;
        check("outs", {bus.out3, bus.out2, bus.out1, bus.out0},
              {m_out[3], m_out[2], m_out[1], m_out[0]});
        check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
        check("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
        check("scan_err", 32'(bus.scan_err), 32'(m_err));
        if (bus.frame_tick && bus.scan_err) check("pulse_excl", 32'd1, 32'd0);
        p_tick += int'(bus.frame_tick);
        p_err  += int'(bus.scan_err);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        bus.an   = a;
        bus.sseg = s;
        repeat (n) tick();
    endtask

    task automatic cap_digit(input int k, input logic [7:0] s);
        logic [3:0] a;
        a = 4'hF;
        a[k] = 1'b0;
        hold(a, s, 30);
        hold(4'hF, 8'hFF, 5);
    endtask

    task automatic do_reset(input int cyc);
        reset    = 1'b0;
        bus.an   = 4'($urandom);
        bus.sseg = 8'($urandom);
        #1;
        check("rst_outs", {bus.out3, bus.out2, bus.out1, bus.out0}, 32'h0);
        check("rst_flags", {28'h0, bus.digit_valid}, 32'h0);
        repeat (cyc) @(posedge clk);
        #1;
        check("rst_hold", {22'h0, bus.frame_tick, bus.scan_err, bus.digit_valid, 4'h0}, 32'h0);
        check("rst_outs2", {bus.out3, bus.out2, bus.out1, bus.out0}, 32'h0);
        model_clear();
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;
        reset    = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'b1110, 8'hC0, 64, 32'h000000C0, 4'b0001, 0, 0};
        tbl[1] = '{4'b1101, 8'hF9, 64, 32'h0000F9C0, 4'b0011, 0, 0};
        tbl[2] = '{4'b1011, 8'hA4, 64, 32'h00A4F9C0, 4'b0111, 0, 0};
        tbl[3] = '{4'b0111, 8'hB0, 64, 32'hB0A4F9C0, 4'b1111, 1, 0};
        tbl[4] = '{4'b1101, 8'h99, 16, 32'hB0A4F9C0, 4'b1111, 0, 0};
        tbl[5] = '{4'b1101, 8'h99, 17, 32'hB0A499C0, 4'b1111, 0, 0};
        tbl[6] = '{4'b1100, 8'h55, 40, 32'hB0A499C0, 4'b1111, 0, 1};
        tbl[7] = '{4'b0000, 8'h12, 40, 32'hB0A499C0, 4'b1111, 0, 1};
        tbl[8] = '{4'b1111, 8'h77, 40, 32'hB0A499C0, 4'b1111, 0, 0};

        model_clear();
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;
        #2;

        // Reset with random inputs, then a long blank period.
        do_reset(5);
        p_tick = 0; p_err = 0;
        hold(4'hF, 8'hFF, 100);
        check("blank_pulses", 32'(p_tick + p_err), 32'd0);
        check("blank_valid", 32'(bus.digit_valid), 32'd0);

        // Exact capture latency: effect lands on the 19th edge (E18).
        do_reset(2);
        bus.an = 4'b1110; bus.sseg = 8'hAB;
        repeat (18) tick();
        check("lat_before", {20'h0, bus.digit_valid, bus.out0}, 32'h0);
        tick();
        check("lat_after", {20'h0, bus.digit_valid, bus.out0}, {20'h0, 4'b0001, 8'hAB});
        hold(4'hF, 8'hFF, 20);

        // Table-driven dwell vectors, each followed by blanking.
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            p_tick = 0; p_err = 0;
            hold(tbl[i].an, tbl[i].sseg, tbl[i].hold);
            hold(4'hF, 8'hFF, 20);
            check($sformatf("vec%0d_outs", i), {bus.out3, bus.out2, bus.out1, bus.out0}, tbl[i].outs);
            check($sformatf("vec%0d_valid", i), 32'(bus.digit_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_ticks", i), 32'(p_tick), 32'(tbl[i].ticks));
            check($sformatf("vec%0d_errs", i), 32'(p_err), 32'(tbl[i].errs));
        end

        // Order independence with a repeated digit.
        do_reset(3);
        p_tick = 0; cap_digit(2, 8'h11); check("ord_t0", 32'(p_tick), 32'd0);
        p_tick = 0; cap_digit(2, 8'h22); check("ord_t1", 32'(p_tick), 32'd0);
        p_tick = 0; cap_digit(0, 8'h33); check("ord_t2", 32'(p_tick), 32'd0);
        p_tick = 0; cap_digit(3, 8'h44); check("ord_t3", 32'(p_tick), 32'd0);
        p_tick = 0; cap_digit(1, 8'h55); check("ord_t4", 32'(p_tick), 32'd1);
        check("ord_outs", {bus.out3, bus.out2, bus.out1, bus.out0}, 32'h44225533);

        // Reset mid-frame discards progress.
        do_reset(3);
        cap_digit(0, 8'h66);
        cap_digit(1, 8'h77);
        do_reset(3);
        p_tick = 0;
        cap_digit(2, 8'h88);
        cap_digit(3, 8'h99);
        check("mid_ticks", 32'(p_tick), 32'd0);
        check("mid_valid", 32'(bus.digit_valid), 32'(4'b1100));

        // Reset in the middle of a dwell count.
        hold(4'b1110, 8'h5A, 10);
        do_reset(3);
        hold(4'b1110, 8'h5A, 10);
        check("midcnt_valid", 32'(bus.digit_valid), 32'd0);
        hold(4'b1110, 8'h5A, 10);
        check("midcnt_out0", 32'(bus.out0), 32'h5A);

        // Random scans against the model.
        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [3:0] a;
            kind = int'($urandom_range(0, 9));
            if (kind == 9) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                if (kind <= 5) begin
                    a = 4'hF;
                    a[$urandom_range(0, 3)] = 1'b0;
                end else if (kind <= 7) begin
                    a = 4'hF;
                end else begin
                    a = 4'($urandom);
                end
                hold(a, 8'($urandom), int'($urandom_range(1, 40)));
            end
        end
        hold(4'hF, 8'hFF, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
